// File: rtl/isa_pkg.sv
// Shared RV32I encoding constants for the program-loader encoder and the
// single-cycle control decoder, so both sides agree on opcode values.
package isa_pkg;

  // opcode[6:2] values; the control decoder matches on these five bits
  localparam logic [4:0] OP5_RTYPE  = 5'b01100;
  localparam logic [4:0] OP5_LOAD   = 5'b00000;
  localparam logic [4:0] OP5_STORE  = 5'b01000;
  localparam logic [4:0] OP5_BRANCH = 5'b11000;

  // Full 7-bit opcodes; RV32I base instructions always end in 2'b11
  localparam logic [6:0] OPC_RTYPE  = {OP5_RTYPE,  2'b11};
  localparam logic [6:0] OPC_LOAD   = {OP5_LOAD,   2'b11};
  localparam logic [6:0] OPC_STORE  = {OP5_STORE,  2'b11};
  localparam logic [6:0] OPC_BRANCH = {OP5_BRANCH, 2'b11};

  // Fixed funct3 values for the non-R-type requests
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  // funct7 choices for R-type (f7b5 selects the SUB/SRA flavour)
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  // Symbolic request kinds on the op_sel input
  typedef enum logic [1:0] {
    OP_RTYPE = 2'd0,
    OP_LW    = 2'd1,
    OP_SW    = 2'd2,
    OP_BEQ   = 2'd3
  } op_sel_e;

  // Loader progress states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_e;

endpackage

// File: rtl/inst_field_encoder.sv
// Purely combinational packer: symbolic instruction fields in, 32-bit RV32I
// word out. No state; the top level registers the result.
module inst_field_encoder
  import isa_pkg::*;
(
  input  logic [1:0]  i_op_sel,
  input  logic [2:0]  i_funct3,
  input  logic        i_f7b5,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [12:0] i_imm,
  output logic [31:0] o_word
);

  // Branch offsets are always even, so imm[0] is intentionally dropped
  logic w_unused_imm0;
  assign w_unused_imm0 = i_imm[0];

  // Select the field layout for the requested instruction format
  always_comb begin
    o_word = 32'h0000_0000;
    case (op_sel_e'(i_op_sel))
      OP_RTYPE: o_word = {(i_f7b5 ? F7_ALT : F7_BASE), i_rs2, i_rs1,
                          i_funct3, i_rd, OPC_RTYPE};
      OP_LW:    o_word = {i_imm[11:0], i_rs1, F3_WORD, i_rd, OPC_LOAD};
      OP_SW:    o_word = {i_imm[11:5], i_rs2, i_rs1, F3_WORD,
                          i_imm[4:0], OPC_STORE};
      OP_BEQ:   o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                          i_imm[4:1], i_imm[11], OPC_BRANCH};
      default:  o_word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/inst_stream_encoder.sv
// Program-loader front end: accepts symbolic instruction requests, encodes
// them and writes them to consecutive instruction-memory words through a
// single registered output stage. Stops accepting once DEPTH words are in.
module inst_stream_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op_sel,
  input  logic [2:0]        funct3,
  input  logic              f7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done
);

  // Count value at which the next accept fills the memory
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  load_state_e       r_state;
  load_state_e       w_state_nxt;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   w_count_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_word;
  logic              w_ready_core;
  logic              w_accept;

  inst_field_encoder u_field_encoder (
    .i_op_sel (op_sel),
    .i_funct3 (funct3),
    .i_f7b5   (f7b5),
    .i_rd     (rd),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_imm    (imm),
    .o_word   (w_word)
  );

  // Clear takes priority over a request, so it also drops ready; reset
  // forces ready low without waiting for a clock edge
  assign w_ready_core = (r_state != ST_FULL) & ~clear;
  assign w_accept     = req_valid & w_ready_core;
  assign req_ready    = w_ready_core & ~rst;

  // Next-state and next-count logic for the loader FSM
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_accept) begin
            w_count_nxt = r_count + 1'b1;
            w_state_nxt = (r_count == LAST_COUNT) ? ST_FULL : ST_LOAD;
          end
        end
        ST_FULL: w_state_nxt = ST_FULL;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and word-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Output stage: capture the encoded word and its address on each accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
      end
    end
  end

  // A clear arriving while a write is presented cancels that write
  assign mem_we    = r_we & ~clear;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign done      = (r_state == ST_FULL);

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Directed bench for inst_stream_encoder, built with DEPTH=4 so the full
// condition is reachable quickly. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active edge.
module tb_inst_stream_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op_sel = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        f7b5 = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [12:0] imm = 13'd0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;
  logic        done;

  int checks = 0;
  int failures = 0;

  inst_stream_encoder #(.ADDR_W(6), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_sel    (op_sel),
    .funct3    (funct3),
    .f7b5      (f7b5),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .done      (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Present one request on the input bus
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [12:0] im);
    req_valid = 1'b1;
    op_sel = op; funct3 = f3; f7b5 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // One-cycle synchronous clear, leaving the bench at a falling edge
  task automatic pulseClear();
    @(negedge clk);
    req_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%0b want=0", mem_we); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0b want=0", req_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
    checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata got=%h want=0", mem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_reset got=%0b want=1", req_ready); end
  endtask

  task automatic test_rtype();
    @(negedge clk);
    applyStimulus(2'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL radd_we got=%0b want=1", mem_we); end
    checks++; if (mem_addr !== 6'd0) begin failures++; $display("[TB] FAIL radd_addr got=%0d want=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h002081B3) begin failures++; $display("[TB] FAIL radd_word got=%h want=002081b3", mem_wdata); end
    checks++; if (count !== 7'd1) begin failures++; $display("[TB] FAIL radd_count got=%0d want=1", count); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL radd_we_fall got=%0b want=0", mem_we); end
    pulseClear();
    checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL clear_count got=%0d want=0", count); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    applyStimulus(2'd1, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL lw_we got=%0b want=1", mem_we); end
    checks++; if (mem_addr !== 6'd0) begin failures++; $display("[TB] FAIL lw_addr got=%0d want=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h00812283) begin failures++; $display("[TB] FAIL lw_word got=%h want=00812283", mem_wdata); end
    applyStimulus(2'd2, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 13'd12);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL sw_we got=%0b want=1", mem_we); end
    checks++; if (mem_addr !== 6'd1) begin failures++; $display("[TB] FAIL sw_addr got=%0d want=1", mem_addr); end
    checks++; if (mem_wdata !== 32'h00512623) begin failures++; $display("[TB] FAIL sw_word got=%h want=00512623", mem_wdata); end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL b2b_we_fall got=%0b want=0", mem_we); end
    checks++; if (count !== 7'd2) begin failures++; $display("[TB] FAIL b2b_count got=%0d want=2", count); end
    pulseClear();
  endtask

  task automatic test_beq();
    @(negedge clk);
    applyStimulus(2'd3, 3'd7, 1'b1, 5'd31, 5'd1, 5'd2, 13'h1FFC);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_wdata !== 32'hFE208EE3) begin failures++; $display("[TB] FAIL beq_word got=%h want=fe208ee3", mem_wdata); end
    checks++; if (mem_wdata[6:2] !== 5'b11000) begin failures++; $display("[TB] FAIL beq_opc5 got=%b want=11000", mem_wdata[6:2]); end
    pulseClear();
  endtask

  task automatic test_full();
    logic [31:0] expWord;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        expWord = 32'h00208033 | (32'(i) << 7);
        if (i <= 4) begin
          checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL full_we%0d got=%0b want=1", i, mem_we); end
          checks++; if (mem_addr !== 6'(i - 1)) begin failures++; $display("[TB] FAIL full_addr%0d got=%0d want=%0d", i, mem_addr, i - 1); end
          checks++; if (mem_wdata !== expWord) begin failures++; $display("[TB] FAIL full_word%0d got=%h want=%h", i, mem_wdata, expWord); end
        end else begin
          checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL full_extra_we%0d got=%0b want=0", i, mem_we); end
        end
        checks++; if (done !== (i >= 4)) begin failures++; $display("[TB] FAIL full_done%0d got=%0b want=%0b", i, done, i >= 4); end
      end
      applyStimulus(2'd0, 3'd0, 1'b0, 5'(i + 1), 5'd1, 5'd2, 13'd0);
    end
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL full_last_we got=%0b want=0", mem_we); end
    req_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL full_done got=%0b want=1", done); end
    checks++; if (count !== 7'd4) begin failures++; $display("[TB] FAIL full_count got=%0d want=4", count); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%0b want=0", req_ready); end
    pulseClear();
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL full_clear_done got=%0b want=0", done); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_clear_ready got=%0b want=1", req_ready); end
  endtask

  task automatic test_clear_squash();
    @(negedge clk);
    applyStimulus(2'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
    @(negedge clk);
    req_valid = 1'b1;
    clear = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL squash_ready got=%0b want=0", req_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL squash_we_now got=%0b want=0", mem_we); end
    @(negedge clk);
    clear = 1'b0;
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL squash_we_next got=%0b want=0", mem_we); end
    checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL squash_count got=%0d want=0", count); end
    applyStimulus(2'd0, 3'd0, 1'b0, 5'd7, 5'd1, 5'd2, 13'd0);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL restart_we got=%0b want=1", mem_we); end
    checks++; if (mem_addr !== 6'd0) begin failures++; $display("[TB] FAIL restart_addr got=%0d want=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h002083B3) begin failures++; $display("[TB] FAIL restart_word got=%h want=002083b3", mem_wdata); end
    checks++; if (count !== 7'd1) begin failures++; $display("[TB] FAIL restart_count got=%0d want=1", count); end
    pulseClear();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(2'd1, 3'd0, 1'b0, 5'(i + 1), 5'd2, 5'd0, 13'(4 * i));
    end
    @(posedge clk);
    #2;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL pre_rst_we got=%0b want=1", mem_we); end
    checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL pre_rst_done got=%0b want=1", done); end
    checks++; if (count !== 7'd4) begin failures++; $display("[TB] FAIL pre_rst_count got=%0d want=4", count); end
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got=%0b want=0", mem_we); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%0b want=0", req_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%0b want=0", done); end
    checks++; if (count !== 7'd0) begin failures++; $display("[TB] FAIL rst_count got=%0d want=0", count); end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready got=%0b want=1", req_ready); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_beq();
    test_full();
    test_clear_squash();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
